// File: rtl/ws2812b_frame_scheduler.sv
// Double-buffered GRB pixel store and frame sequencer for a WS2812B driver.
// Host fills the back bank; a commit swaps banks at the next frame start.
module ws2812b_frame_scheduler #(
  parameter int MAX_POS      = 16,
  parameter int FRAME_CLKS   = 27000,
  parameter int GAP_CLKS     = 4,
  parameter int REFRESH_CLKS = 0,
  parameter int ADDR_W       = (MAX_POS > 1) ? $clog2(MAX_POS) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [23:0]       i_wr_data,
  input  logic              i_commit,
  output logic              o_commit_ack,
  output logic              o_frame_done,
  output logic              o_busy,
  output logic              o_update_frame,
  input  logic [ADDR_W-1:0] i_program_led_number,
  output logic [7:0]        o_program_red_intensity,
  output logic [7:0]        o_program_green_intensity,
  output logic [7:0]        o_program_blue_intensity
);

  localparam int IDX_W     = (MAX_POS > 1) ? $clog2(MAX_POS) : 1;
  localparam int PHASE_MAX = (FRAME_CLKS > GAP_CLKS) ? FRAME_CLKS : GAP_CLKS;
  localparam int FCNT_W    = $clog2(PHASE_MAX + 1);
  localparam int RCNT_W    = (REFRESH_CLKS > 0) ? $clog2(REFRESH_CLKS + 1) : 1;

  localparam logic [FCNT_W-1:0] FRAME_LAST  = FCNT_W'(FRAME_CLKS - 1);
  localparam logic [FCNT_W-1:0] GAP_LAST    = FCNT_W'(GAP_CLKS - 1);
  localparam logic [RCNT_W-1:0] REFRESH_MAX = RCNT_W'(REFRESH_CLKS);
  localparam logic [ADDR_W:0]   POS_LIMIT   = (ADDR_W + 1)'(MAX_POS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [FCNT_W-1:0]   r_frame_cnt;
  logic [FCNT_W-1:0]   w_frame_cnt_d;
  logic [RCNT_W-1:0]   r_refresh_cnt;
  logic                r_commit_pending;
  logic                r_front_sel;
  logic                r_update_frame;
  logic                r_busy;
  logic                r_commit_ack;
  logic                r_frame_done;
  logic                w_update_frame_d;
  logic                w_busy_d;
  logic                w_commit_ack_d;
  logic                w_frame_done_d;
  logic                w_refresh_due;
  logic                w_start;
  logic                w_swap;
  logic                w_send_last;
  logic                w_gap_last;
  logic                w_led_ok;
  logic [IDX_W-1:0]    w_led_idx;
  logic [23:0]         w_front_pix;
  logic [23:0]         r_bank0 [MAX_POS];
  logic [23:0]         r_bank1 [MAX_POS];
  logic [23:0]         w_front [MAX_POS];

  assign w_refresh_due = (REFRESH_CLKS != 0) && (r_refresh_cnt >= REFRESH_MAX);
  assign w_start       = (r_state == ST_IDLE) && i_enable && (r_commit_pending || w_refresh_due);
  assign w_swap        = w_start && r_commit_pending;
  assign w_send_last   = (r_state == ST_SEND) && (r_frame_cnt == FRAME_LAST);
  assign w_gap_last    = (r_state == ST_GAP) && (r_frame_cnt == GAP_LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: w_next_state = w_start ? ST_SEND : ST_IDLE;
      ST_SEND: w_next_state = w_send_last ? ST_GAP : ST_SEND;
      ST_GAP:  w_next_state = w_gap_last ? ST_IDLE : ST_GAP;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and the shared SEND/GAP phase counter.
  always_comb begin
    w_update_frame_d = (w_next_state == ST_SEND);
    w_busy_d         = (w_next_state != ST_IDLE);
    w_commit_ack_d   = w_swap;
    w_frame_done_d   = w_gap_last;
    w_frame_cnt_d    = {FCNT_W{1'b0}};
    case (r_state)
      ST_IDLE: w_frame_cnt_d = {FCNT_W{1'b0}};
      ST_SEND: w_frame_cnt_d = w_send_last ? {FCNT_W{1'b0}} : r_frame_cnt + FCNT_W'(1);
      ST_GAP:  w_frame_cnt_d = w_gap_last  ? {FCNT_W{1'b0}} : r_frame_cnt + FCNT_W'(1);
      default: w_frame_cnt_d = {FCNT_W{1'b0}};
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_update_frame <= 1'b0;
      r_busy         <= 1'b0;
      r_commit_ack   <= 1'b0;
      r_frame_done   <= 1'b0;
      r_frame_cnt    <= {FCNT_W{1'b0}};
    end else begin
      r_update_frame <= w_update_frame_d;
      r_busy         <= w_busy_d;
      r_commit_ack   <= w_commit_ack_d;
      r_frame_done   <= w_frame_done_d;
      r_frame_cnt    <= w_frame_cnt_d;
    end
  end

  // A commit landing in the start cycle survives the swap and waits for the next frame.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_commit_pending <= 1'b0;
      r_front_sel      <= 1'b0;
      r_refresh_cnt    <= {RCNT_W{1'b0}};
    end else begin
      r_commit_pending <= (r_commit_pending && !w_swap) || i_commit;
      if (w_swap) begin
        r_front_sel <= ~r_front_sel;
      end else begin
        r_front_sel <= r_front_sel;
      end
      if (w_start) begin
        r_refresh_cnt <= {RCNT_W{1'b0}};
      end else if (r_refresh_cnt < REFRESH_MAX) begin
        r_refresh_cnt <= r_refresh_cnt + RCNT_W'(1);
      end else begin
        r_refresh_cnt <= r_refresh_cnt;
      end
    end
  end

  // Writes use the pre-swap bank select, so a write on the swap edge joins the new front.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < MAX_POS; i++) begin
        r_bank0[i] <= 24'h0;
        r_bank1[i] <= 24'h0;
      end
    end else begin
      for (int i = 0; i < MAX_POS; i++) begin
        if (i_wr_en && (i_wr_addr == ADDR_W'(i))) begin
          if (r_front_sel) begin
            r_bank0[i] <= i_wr_data;
          end else begin
            r_bank1[i] <= i_wr_data;
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < MAX_POS; i++) begin
      w_front[i] = r_front_sel ? r_bank1[i] : r_bank0[i];
    end
  end

  assign w_led_ok    = ({1'b0, i_program_led_number} < POS_LIMIT);
  assign w_led_idx   = i_program_led_number[IDX_W-1:0];
  assign w_front_pix = w_led_ok ? w_front[w_led_idx] : 24'h0;

  assign o_program_green_intensity = w_front_pix[23:16];
  assign o_program_red_intensity   = w_front_pix[15:8];
  assign o_program_blue_intensity  = w_front_pix[7:0];
  assign o_update_frame            = r_update_frame;
  assign o_busy                    = r_busy;
  assign o_commit_ack              = r_commit_ack;
  assign o_frame_done              = r_frame_done;

endmodule

// File: tb/tb_ws2812b_frame_scheduler.sv
// Directed bench for ws2812b_frame_scheduler: one instance without refresh,
// one with REFRESH_CLKS=300, both with MAX_POS=4 and a 3-bit pixel address.
module tb_ws2812b_frame_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        en, wr_en, commit;
  logic [2:0]  wr_addr, led;
  logic [23:0] wr_data;
  logic        ack, done, busy, uf;
  logic [7:0]  red, green, blue;
  wire  [23:0] a_pix = {green, red, blue};

  logic        rf_en, rf_wr_en, rf_commit;
  logic [2:0]  rf_wr_addr, rf_led;
  logic [23:0] rf_wr_data;
  logic        rf_ack, rf_done, rf_busy, rf_uf;
  logic [7:0]  rf_red, rf_green, rf_blue;

  int total = 0;
  int bad   = 0;

  ws2812b_frame_scheduler #(
    .MAX_POS(4), .FRAME_CLKS(100), .GAP_CLKS(4), .REFRESH_CLKS(0), .ADDR_W(3)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_commit(commit), .o_commit_ack(ack), .o_frame_done(done),
    .o_busy(busy), .o_update_frame(uf), .i_program_led_number(led),
    .o_program_red_intensity(red), .o_program_green_intensity(green),
    .o_program_blue_intensity(blue)
  );

  ws2812b_frame_scheduler #(
    .MAX_POS(4), .FRAME_CLKS(100), .GAP_CLKS(4), .REFRESH_CLKS(300), .ADDR_W(3)
  ) dut_rf (
    .i_clk(clk), .i_reset(rst), .i_enable(rf_en), .i_wr_en(rf_wr_en), .i_wr_addr(rf_wr_addr),
    .i_wr_data(rf_wr_data), .i_commit(rf_commit), .o_commit_ack(rf_ack), .o_frame_done(rf_done),
    .o_busy(rf_busy), .o_update_frame(rf_uf), .i_program_led_number(rf_led),
    .o_program_red_intensity(rf_red), .o_program_green_intensity(rf_green),
    .o_program_blue_intensity(rf_blue)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input logic [2:0] a, input logic [23:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic peek(input logic [2:0] idx, output logic [23:0] px);
    led = idx;
    #1;
    px = a_pix;
  endtask

  initial begin
    logic [23:0] px;
    logic [23:0] orig [4];
    int n, m, acks, rises, dones, t1, t2;
    logic stable, prev_uf, colour_bad;

    orig[0] = 24'h112233; orig[1] = 24'h445566; orig[2] = 24'h778899; orig[3] = 24'hAABBCC;
    en = 1'b1; wr_en = 1'b0; commit = 1'b0; wr_addr = 3'd0; wr_data = 24'h0; led = 3'd0;
    rf_en = 1'b1; rf_wr_en = 1'b0; rf_commit = 1'b0; rf_wr_addr = 3'd0; rf_wr_data = 24'h0;
    rf_led = 3'd0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    check("rst_uf", 32'(uf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    peek(3'd2, px);
    check("rst_pix", 32'(px), 32'd0);

    for (int i = 0; i < 4; i++) write_px(3'(i), orig[i]);
    peek(3'd2, px);
    check("back_hidden", 32'(px), 32'd0);

    // First commit: pending after one edge, swap/ack on the next.
    commit = 1'b1; tick(); commit = 1'b0;
    check("ack_early", 32'(ack), 32'd0);
    check("uf_early", 32'(uf), 32'd0);
    tick();
    check("ack1", 32'(ack), 32'd1);
    check("uf_rise", 32'(uf), 32'd1);
    check("busy_send", 32'(busy), 32'd1);
    peek(3'd2, px);
    check("green2", 32'(green), 32'h77);
    check("red2", 32'(red), 32'h88);
    check("blue2", 32'(blue), 32'h99);

    peek(3'd1, px);
    n = 0; stable = 1'b1;
    wr_addr = 3'd1; wr_data = 24'hFFFFFF;
    while (uf === 1'b1 && n < 300) begin
      n++;
      if (a_pix !== 24'h445566) stable = 1'b0;
      wr_en = (n == 10);
      tick();
    end
    wr_en = 1'b0;
    check("frame_len", 32'(n), 32'd100);
    check("send_stable", 32'(stable), 32'd1);
    check("busy_gap", 32'(busy), 32'd1);
    m = 0;
    while (done !== 1'b1 && m < 20) begin
      tick();
      m++;
    end
    check("gap_len", 32'(m), 32'd4);
    check("busy_idle", 32'(busy), 32'd0);
    tick();
    check("done_pulse", 32'(done), 32'd0);

    commit = 1'b1; tick(); commit = 1'b0; tick();
    check("ack2", 32'(ack), 32'd1);
    peek(3'd1, px);
    check("px1_new", 32'(px), 32'hFFFFFF);
    peek(3'd2, px);
    check("px2_nocopy", 32'(px), 32'd0);

    // Three commits during frame 2 collapse into a single extra frame.
    acks = 0; rises = 0; dones = 0; prev_uf = uf;
    for (int i = 0; i < 400; i++) begin
      commit = (i == 5) || (i == 20) || (i == 50);
      tick();
      if (ack) acks++;
      if (uf && !prev_uf) rises++;
      if (done) dones++;
      prev_uf = uf;
    end
    commit = 1'b0;
    check("multi_acks", 32'(acks), 32'd1);
    check("multi_frames", 32'(rises), 32'd1);
    check("multi_dones", 32'(dones), 32'd2);

    // Write on the swap edge lands in the bank that becomes front.
    commit = 1'b1; tick(); commit = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 24'hCAFE01;
    tick();
    wr_en = 1'b0;
    check("ack3", 32'(ack), 32'd1);
    peek(3'd0, px);
    check("collide", 32'(px), 32'hCAFE01);
    peek(3'd1, px);
    check("f4_px1", 32'(px), 32'hFFFFFF);
    write_px(3'd5, 24'h123456);
    peek(3'd5, px);
    check("oob_read", 32'(px), 32'd0);
    m = 0;
    while (done !== 1'b1 && m < 300) begin
      tick();
      m++;
    end
    check("f4_done", 32'(done), 32'd1);

    en = 1'b0;
    commit = 1'b1; tick(); commit = 1'b0;
    rises = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (uf) rises++;
    end
    check("disabled_hold", 32'(rises), 32'd0);
    en = 1'b1;
    tick();
    check("held_ack", 32'(ack), 32'd1);
    check("held_uf", 32'(uf), 32'd1);
    for (int i = 0; i < 4; i++) begin
      peek(3'(i), px);
      check($sformatf("oob_keep%0d", i), 32'(px), 32'(orig[i]));
    end

    // Reset in the middle of SEND with a commit pending.
    repeat (20) tick();
    commit = 1'b1; tick(); commit = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mid_uf", 32'(uf), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    peek(3'd0, px);
    check("rst_mid_pix", 32'(px), 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    rises = 0; dones = 0; prev_uf = uf;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (uf && !prev_uf) rises++;
      if (done) dones++;
      prev_uf = uf;
    end
    check("rst_no_frame", 32'(rises), 32'd0);
    check("rst_no_done", 32'(dones), 32'd0);

    // Auto-refresh instance: frames without commits, front bank never swapped.
    rst = 1'b1; tick(); rst = 1'b0;
    acks = 0; rises = 0; dones = 0; prev_uf = rf_uf; t1 = 0; t2 = 0; colour_bad = 1'b0;
    rf_wr_addr = 3'd0; rf_wr_data = 24'h0A0B0C;
    for (int i = 0; i < 950; i++) begin
      rf_wr_en = (i == 0);
      tick();
      if (rf_ack) acks++;
      if (rf_done) dones++;
      if (rf_uf && !prev_uf) begin
        rises++;
        if (rises == 1) t1 = i + 1;
        if (rises == 2) t2 = i + 1;
      end
      if ({rf_green, rf_red, rf_blue} !== 24'h0) colour_bad = 1'b1;
      prev_uf = rf_uf;
    end
    rf_wr_en = 1'b0;
    check("rf_frames", 32'(rises), 32'd3);
    check("rf_first", 32'(t1 >= 300 && t1 <= 301), 32'd1);
    check("rf_period", 32'((t2 - t1) >= 300 && (t2 - t1) <= 301), 32'd1);
    check("rf_no_ack", 32'(acks), 32'd0);
    check("rf_dones", 32'(dones), 32'd2);
    check("rf_front_kept", 32'(colour_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
